float_keystream_extractor: RTL and testbench
============================================

FLOAT_KEYSTREAM_EXTRACTOR -- requirements
Module: float_keystream_extractor

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning key-byte FIFO depth (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset: one clock, reset synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  upstream float adder Result word is valid.
REQ-005 SHALL have port in_data  input  32  IEEE-754 single-precision word from the adder stage.
REQ-006 SHALL have port in_ready  output  1  block can accept in_data this cycle.
REQ-007 SHALL have port key_valid  output  1  key_byte holds a valid keystream byte.
REQ-008 SHALL have port key_byte  output  8  keystream byte at FIFO head.
REQ-009 SHALL have port key_ready  input  1  downstream pixel-XOR stage consumes key_byte.
REQ-010 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-011 SHALL have port drop_count  output  16  count of rejected input words, saturating.

Function
REQ-012 SHALL accept an input word on a rising edge where in_valid && in_ready.
REQ-013 SHALL drive in_ready = (level < DEPTH), with no same-cycle pop bypass when full.
REQ-014 SHALL reject an accepted word when in_data[30:23] == 8'hFF (Inf/NaN) or == 8'h00 (zero/denormal).
REQ-015 SHALL, on rejection, write nothing to the FIFO and increment drop_count, holding at 16'hFFFF.
REQ-016 SHALL compute key = in_data[22:15] ^ in_data[14:7] ^ {in_data[6:0], in_data[31]} for non-rejected words.
REQ-017 SHALL write key into the FIFO on the accepting edge; key_valid rises on the following cycle if the FIFO was empty (latency 1).
REQ-018 SHALL present the FIFO head on key_byte whenever key_valid is high, stable until popped.
REQ-019 SHALL drive key_valid = (level != 0) and pop one entry on an edge where key_valid && key_ready.
REQ-020 SHALL, on a simultaneous push and pop, keep level unchanged and preserve FIFO order.
REQ-021 SHALL wrap read and write pointers modulo DEPTH.
REQ-022 SHALL ignore key_ready while key_valid is low, and in_data while in_valid or in_ready is low.
REQ-023 SHALL not alter drop_count or FIFO contents for a rejected word that coincides with a pop, other than the pop itself.

Reset
REQ-024 SHALL, while rst is high at a clock edge, clear pointers, level = 0, drop_count = 0, key_valid = 0, key_byte = 8'h00.
REQ-025 SHALL drive in_ready = 1 on the first cycle after rst is released.
REQ-026 SHALL discard any in-flight handshake on the edge where rst is high, including FIFO contents when asserted mid-stream.

Structure
REQ-027 SHALL place the FLOAT_EXP_SPECIAL (8'hFF) and FLOAT_EXP_ZERO (8'h00) constants and the key-extraction bit-slice widths in the shared float package used by the adder stage.
REQ-028 SHALL implement storage as one sub-module, keystream_fifo (synchronous, DEPTH x 8, registered head).
REQ-029 SHALL keep classification and key extraction combinational in the top module, with no extra pipeline register.

Verification
REQ-030 SHALL cover: reset, then in_data=32'h3FC00000 accepted -> next cycle key_valid=1, key_byte=8'h80, level=1.
REQ-031 SHALL cover: in_data=32'hBF800001 -> key_byte=8'h03; in_data=32'h7F800000 -> no push, drop_count=1.
REQ-032 SHALL cover: key_ready=0 with DEPTH+1 valid words offered -> level=DEPTH, in_ready=0, the extra word is not accepted, and the FIFO drains in input order.
REQ-033 SHALL cover: FIFO full, key_ready=1 and in_valid=1 -> one pop, in_ready rises next cycle, and the word is then accepted with level staying at DEPTH.
REQ-034 SHALL cover: 65540 consecutive in_data=32'h00000000 -> drop_count saturates at 16'hFFFF and key_valid stays 0.
REQ-035 SHALL cover: rst pulsed with level=3 -> next cycle level=0, key_valid=0, drop_count=0, in_ready=1.

Source files
------------

// File: rtl/float_keystream_extractor_pkg.sv
// Shared float definitions used by the adder stage and the keystream extractor.
// Holds the exponent classification constants and the key bit-slice layout.
package float_keystream_extractor_pkg;

  localparam logic [7:0] FLOAT_EXP_SPECIAL = 8'hFF;
  localparam logic [7:0] FLOAT_EXP_ZERO    = 8'h00;

  localparam int KEY_W       = 8;
  localparam int KEY_HI_LSB  = 15;
  localparam int KEY_MID_LSB = 7;
  localparam int KEY_LO_W    = 7;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } float32_t;

  // Inf/NaN and zero/denormal words carry no usable mantissa entropy.
  function automatic logic is_rejected(input float32_t f);
    return (f.exp == FLOAT_EXP_SPECIAL) || (f.exp == FLOAT_EXP_ZERO);
  endfunction

  function automatic logic [KEY_W-1:0] extract_key(input float32_t f);
    return f.mant[KEY_HI_LSB +: KEY_W]
         ^ f.mant[KEY_MID_LSB +: KEY_W]
         ^ {f.mant[0 +: KEY_LO_W], f.sign};
  endfunction

endpackage

// File: rtl/float_keystream_extractor_fifo.sv
// keystream_fifo: DEPTH x 8 synchronous FIFO with a registered head byte.
// The head register is preloaded with the next entry so the read side has no memory-to-output path.
module keystream_fifo
  import float_keystream_extractor_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [KEY_W-1:0]           wr_data,
  input  logic                       pop,
  output logic [KEY_W-1:0]           head,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] ONE_L   = LVL_W'(1);

  logic [KEY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [LVL_W-1:0] level_q;
  logic [KEY_W-1:0] head_q;
  logic [KEY_W-1:0] head_nxt;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level_q == DEPTH_L);
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_ptr_inc = rd_ptr + PTR_W'(1);

  always_comb begin
    head_nxt = head_q;
    if (pop_ok) begin
      if (level_q == ONE_L) begin
        if (push_ok) head_nxt = wr_data;
      end else begin
        head_nxt = mem[rd_ptr_inc];
      end
    end else if (empty && push_ok) begin
      head_nxt = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      head_q  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr_inc;
      head_q <= head_nxt;
      unique case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + ONE_L;
        2'b01:   level_q <= level_q - ONE_L;
        default: level_q <= level_q;
      endcase
    end
  end

  assign head  = head_q;
  assign level = level_q;

endmodule

// File: rtl/float_keystream_extractor.sv
// Turns adder-stage float words into keystream bytes for the pixel-XOR stage.
// Special and zero/denormal words are dropped and counted; the rest feed a small FIFO.
module float_keystream_extractor
  import float_keystream_extractor_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [31:0]             in_data,
  output logic                    in_ready,
  output logic                    key_valid,
  output logic [7:0]              key_byte,
  input  logic                    key_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic [15:0]             drop_count
);

  float32_t         in_word;
  logic             accept;
  logic             reject;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [KEY_W-1:0] key;
  logic [15:0]      drop_q;

  assign in_word = in_data;
  assign accept  = in_valid && in_ready;
  assign reject  = accept && is_rejected(in_word);
  assign push    = accept && !is_rejected(in_word);
  assign key     = extract_key(in_word);

  assign in_ready  = !fifo_full;
  assign key_valid = !fifo_empty;
  assign pop       = key_valid && key_ready;

  keystream_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (key),
    .pop     (pop),
    .head    (key_byte),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (reject && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_count = drop_q;

endmodule

// File: tb/tb_float_keystream_extractor.sv
// Directed bench for float_keystream_extractor: hand-computed keys, full/drain order,
// rejection counting with saturation, and reset behaviour.
module tb_float_keystream_extractor;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        key_valid;
  logic [7:0]  key_byte;
  logic        key_ready;
  logic [2:0]  level;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  float_keystream_extractor #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .key_valid  (key_valid),
    .key_byte   (key_byte),
    .key_ready  (key_ready),
    .level      (level),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Normal-exponent word whose key equals k (only mantissa[22:15] set).
  function automatic logic [31:0] mk_word(input logic [7:0] k);
    return 32'h2000_0000 | ({24'h0, k} << 15);
  endfunction

  logic [7:0] exp_keys [5];
  logic       saw_valid;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; key_ready = 1'b0;
    exp_keys[0] = 8'h11; exp_keys[1] = 8'h22; exp_keys[2] = 8'h33;
    exp_keys[3] = 8'h44; exp_keys[4] = 8'h55;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_level", level, 0);
    check_eq("rst_key_valid", key_valid, 0);
    check_eq("rst_key_byte", key_byte, 8'h00);
    check_eq("rst_drop", drop_count, 0);
    check_eq("rst_in_ready", in_ready, 1);

    // First key: 3FC00000 -> 0x80, visible one cycle later
    in_valid = 1'b1; in_data = 32'h3FC0_0000;
    tick();
    check_eq("k1_valid", key_valid, 1);
    check_eq("k1_byte", key_byte, 8'h80);
    check_eq("k1_level", level, 1);

    in_data = 32'hBF80_0001;
    tick();
    in_valid = 1'b0;
    check_eq("k2_level", level, 2);
    check_eq("k2_head_stable", key_byte, 8'h80);
    key_ready = 1'b1;
    tick();
    check_eq("k2_byte", key_byte, 8'h03);
    check_eq("k2_level_after_pop", level, 1);
    tick();
    key_ready = 1'b0;
    check_eq("drained_valid", key_valid, 0);

    // Infinity is rejected
    in_valid = 1'b1; in_data = 32'h7F80_0000;
    tick();
    in_valid = 1'b0;
    check_eq("inf_drop", drop_count, 1);
    check_eq("inf_level", level, 0);
    check_eq("inf_valid", key_valid, 0);

    // Fill with DEPTH+1 offers while downstream stalls
    for (int i = 0; i < DEPTH + 1; i++) begin
      in_valid = 1'b1; in_data = mk_word(exp_keys[i]);
      tick();
    end
    check_eq("full_level", level, DEPTH);
    check_eq("full_in_ready", in_ready, 0);
    check_eq("full_head", key_byte, 8'h11);
    check_eq("full_drop_unchanged", drop_count, 1);

    // Single pop while the extra word is still offered
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    check_eq("pop_level", level, DEPTH - 1);
    check_eq("pop_in_ready", in_ready, 1);
    check_eq("pop_head", key_byte, 8'h22);
    tick();
    in_valid = 1'b0;
    check_eq("refill_level", level, DEPTH);
    check_eq("refill_in_ready", in_ready, 0);

    key_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check_eq($sformatf("drain_%0d", i), key_byte, exp_keys[i]);
      tick();
    end
    key_ready = 1'b0;
    check_eq("drain_empty_level", level, 0);
    check_eq("drain_empty_valid", key_valid, 0);

    // Simultaneous push and pop keeps level and order
    in_valid = 1'b1; in_data = mk_word(8'h66);
    tick();
    in_data = mk_word(8'h77); key_ready = 1'b1;
    tick();
    in_valid = 1'b0; key_ready = 1'b0;
    check_eq("pushpop_level", level, 1);
    check_eq("pushpop_head", key_byte, 8'h77);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;

    // Mid-stream reset with three entries
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = mk_word(exp_keys[i]);
      tick();
    end
    in_valid = 1'b0;
    check_eq("pre_rst_level", level, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_level", level, 0);
    check_eq("mid_rst_valid", key_valid, 0);
    check_eq("mid_rst_drop", drop_count, 0);
    check_eq("mid_rst_in_ready", in_ready, 1);
    check_eq("mid_rst_key_byte", key_byte, 8'h00);

    // Zero words until the drop counter saturates
    saw_valid = 1'b0;
    in_valid = 1'b1; in_data = 32'h0000_0000;
    for (int i = 0; i < 65535; i++) begin
      tick();
      if (key_valid) saw_valid = 1'b1;
    end
    check_eq("sat_reach", drop_count, 16'hFFFF);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (key_valid) saw_valid = 1'b1;
    end
    in_valid = 1'b0;
    check_eq("sat_hold", drop_count, 16'hFFFF);
    check_eq("sat_no_valid", saw_valid, 0);
    check_eq("sat_level", level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
